// File: rtl/axi_aw_route_arbiter.sv
// axi_aw_route_arbiter: AW arbiter for one master port, pushes the winner's {BIN_ID, OH_ID} into the write-data ID FIFO.
// Define AW_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module axi_aw_route_arbiter #(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_ID_IN     = 4,
    parameter int AXI_USER_W    = 6,
    parameter int N_TARG_PORT   = 7,
    parameter int LOG_N_TARG    = $clog2(N_TARG_PORT),
    parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        test_en_i,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]       awid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0]   awaddr_i,
    input  logic [N_TARG_PORT-1:0][7:0]                 awlen_i,
    input  logic [N_TARG_PORT-1:0][2:0]                 awsize_i,
    input  logic [N_TARG_PORT-1:0][1:0]                 awburst_i,
    input  logic [N_TARG_PORT-1:0]                      awlock_i,
    input  logic [N_TARG_PORT-1:0][3:0]                 awcache_i,
    input  logic [N_TARG_PORT-1:0][2:0]                 awprot_i,
    input  logic [N_TARG_PORT-1:0][3:0]                 awregion_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]      awuser_i,
    input  logic [N_TARG_PORT-1:0][3:0]                 awqos_i,
    input  logic [N_TARG_PORT-1:0]                      awvalid_i,
    output logic [N_TARG_PORT-1:0]                      awready_o,
    output logic [AXI_ID_OUT-1:0]                       awid_o,
    output logic [AXI_ADDRESS_W-1:0]                    awaddr_o,
    output logic [7:0]                                  awlen_o,
    output logic [2:0]                                  awsize_o,
    output logic [1:0]                                  awburst_o,
    output logic                                        awlock_o,
    output logic [3:0]                                  awcache_o,
    output logic [2:0]                                  awprot_o,
    output logic [3:0]                                  awregion_o,
    output logic [AXI_USER_W-1:0]                       awuser_o,
    output logic [3:0]                                  awqos_o,
    output logic                                        awvalid_o,
    input  logic                                        awready_i,
    output logic                                        push_ID_o,
    output logic [LOG_N_TARG+N_TARG_PORT-1:0]           ID_o,
    input  logic                                        grant_FIFO_ID_i
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_d;
    logic [LOG_N_TARG-1:0] lock_idx, lock_idx_d, arb_idx, lo_idx, w;
    logic lo_found, any_req, hs;
    logic unused_test_en;
    assign unused_test_en = test_en_i;
    always_comb begin
        lo_idx = '0;
        lo_found = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++)
            if (awvalid_i[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx = LOG_N_TARG'(i);
            end
    end
`ifdef AW_ROUND_ROBIN_EN
    logic [LOG_N_TARG-1:0] rr_ptr, hi_idx;
    logic hi_found;
    // first request at or above the pointer, else wrap to the lowest request
    always_comb begin
        hi_idx = '0;
        hi_found = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++)
            if (awvalid_i[i] && !hi_found && LOG_N_TARG'(i) >= rr_ptr) begin
                hi_found = 1'b1;
                hi_idx = LOG_N_TARG'(i);
            end
    end
    assign arb_idx = hi_found ? hi_idx : lo_idx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            rr_ptr <= '0;
        else if (hs)
            rr_ptr <= (w == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : w + LOG_N_TARG'(1);
`else
    assign arb_idx = lo_idx;
`endif
    assign w          = (state == LOCKED) ? lock_idx : arb_idx;
    assign any_req    = (state == LOCKED) || lo_found;
    assign awvalid_o  = any_req && grant_FIFO_ID_i;
    assign hs         = awvalid_o && awready_i;
    assign push_ID_o  = hs;
    assign awready_o  = hs ? N_TARG_PORT'(1) << w : '0;
    assign ID_o       = {w, N_TARG_PORT'(1) << w};
    assign awid_o     = {w, awid_i[w]};
    assign awaddr_o   = awaddr_i[w];
    assign awlen_o    = awlen_i[w];
    assign awsize_o   = awsize_i[w];
    assign awburst_o  = awburst_i[w];
    assign awlock_o   = awlock_i[w];
    assign awcache_o  = awcache_i[w];
    assign awprot_o   = awprot_i[w];
    assign awregion_o = awregion_i[w];
    assign awuser_o   = awuser_i[w];
    assign awqos_o    = awqos_i[w];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            lock_idx <= '0;
        end else begin
            state <= state_d;
            lock_idx <= lock_idx_d;
        end
    always_comb begin
        state_d = state;
        lock_idx_d = lock_idx;
        if (hs)
            state_d = IDLE;
        else if (awvalid_o) begin
            state_d = LOCKED;
            lock_idx_d = w;
        end
    end
    // a stalled requester must hold valid, and the FIFO cannot lose space while we hold it
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        state == LOCKED |-> awvalid_i[lock_idx] && grant_FIFO_ID_i)
        else $error("locked requester dropped awvalid_i or FIFO grant");
endmodule

// File: tb/tb_axi_aw_route_arbiter.sv
// tb_axi_aw_route_arbiter: directed test-plan steps plus random traffic checked against a queue-free behavioural model.
module tb_axi_aw_route_arbiter;
    localparam int N = 7, LN = 3, IDW = 4, AW = 32, UW = 6;
`ifdef AW_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, test_en_i = 1'b0;
    logic [N-1:0][IDW-1:0] awid_i;
    logic [N-1:0][AW-1:0] awaddr_i;
    logic [N-1:0][7:0] awlen_i;
    logic [N-1:0][2:0] awsize_i, awprot_i;
    logic [N-1:0][1:0] awburst_i;
    logic [N-1:0] awlock_i, awvalid_i, awready_o;
    logic [N-1:0][3:0] awcache_i, awregion_i, awqos_i;
    logic [N-1:0][UW-1:0] awuser_i;
    logic [IDW+LN-1:0] awid_o;
    logic [AW-1:0] awaddr_o;
    logic [7:0] awlen_o;
    logic [2:0] awsize_o, awprot_o;
    logic [1:0] awburst_o;
    logic awlock_o, awvalid_o, awready_i = 1'b0, push_ID_o, grant_FIFO_ID_i = 1'b0;
    logic [3:0] awcache_o, awregion_o, awqos_o;
    logic [UW-1:0] awuser_o;
    logic [LN+N-1:0] ID_o;
    int checks = 0, errors = 0;
    int m_rr = 0, m_lidx = 0, last_w = -1;
    bit m_lock = 1'b0;
    logic [LN+N-1:0] last_id;
    logic [IDW+LN-1:0] last_awid;
    int wins[8];

    axi_aw_route_arbiter dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awlock_i(awlock_i), .awcache_i(awcache_i), .awprot_i(awprot_i),
        .awregion_i(awregion_i), .awuser_i(awuser_i), .awqos_i(awqos_i), .awvalid_i(awvalid_i),
        .awready_o(awready_o), .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awsize_o(awsize_o), .awburst_o(awburst_o), .awlock_o(awlock_o), .awcache_o(awcache_o),
        .awprot_o(awprot_o), .awregion_o(awregion_o), .awuser_o(awuser_o), .awqos_o(awqos_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .push_ID_o(push_ID_o), .ID_o(ID_o),
        .grant_FIFO_ID_i(grant_FIFO_ID_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_port(input int p);
        awid_i[p] = IDW'($urandom);
        awaddr_i[p] = $urandom;
        awlen_i[p] = 8'($urandom);
        awsize_i[p] = 3'($urandom);
        awburst_i[p] = 2'($urandom);
        awlock_i[p] = 1'($urandom);
        awcache_i[p] = 4'($urandom);
        awprot_i[p] = 3'($urandom);
        awregion_i[p] = 4'($urandom);
        awuser_i[p] = UW'($urandom);
        awqos_i[p] = 4'($urandom);
    endtask

    // one cycle: drive at negedge, compare combinational outputs to the model, advance the model
    task automatic step(input logic [N-1:0] v, input logic rdy, input logic gnt);
        int w;
        bit valid, hs;
        @(negedge clk);
        for (int p = 0; p < N; p++)
            if (!(m_lock && p == m_lidx)) rand_port(p);
        if (m_lock) begin
            v[m_lidx] = 1'b1;
            gnt = 1'b1;
        end
        awvalid_i = v;
        awready_i = rdy;
        grant_FIFO_ID_i = gnt;
        #1;
        w = -1;
        if (m_lock) w = m_lidx;
        else for (int k = 0; k < N; k++) if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
        valid = (w >= 0) && gnt;
        hs = valid && rdy;
        chk("awvalid_o", 64'(awvalid_o), 64'(valid));
        chk("push_ID_o", 64'(push_ID_o), 64'(hs));
        chk("awready_o", 64'(awready_o), hs ? 64'(1) << w : 64'(0));
        if (w >= 0) begin
            chk("ID_o", 64'(ID_o), 64'({LN'(w), N'(64'(1) << w)}));
            chk("awid_o", 64'(awid_o), 64'({LN'(w), awid_i[w]}));
            chk("awaddr_o", 64'(awaddr_o), 64'(awaddr_i[w]));
            chk("awlen_o", 64'(awlen_o), 64'(awlen_i[w]));
            chk("awburst_o", 64'(awburst_o), 64'(awburst_i[w]));
            chk("awuser_o", 64'(awuser_o), 64'(awuser_i[w]));
            chk("awqos_o", 64'(awqos_o), 64'(awqos_i[w]));
        end
        last_id = ID_o;
        last_awid = awid_o;
        last_w = hs ? w : -1;
        if (hs) begin
            m_lock = 1'b0;
            if (RR) m_rr = (w + 1) % N;
        end else if (valid) begin
            m_lock = 1'b1;
            m_lidx = w;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        awvalid_i = '0;
        awready_i = 1'b1;
        grant_FIFO_ID_i = 1'b1;
        m_rr = 0;
        m_lock = 1'b0;
        #1;
        chk("reset awvalid_o", 64'(awvalid_o), 64'(0));
        chk("reset push_ID_o", 64'(push_ID_o), 64'(0));
        chk("reset awready_o", 64'(awready_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < N; p++) rand_port(p);
        awvalid_i = '0;
        do_reset();
        step(7'b0100100, 1'b1, 1'b1);
        chk("tp first ID_o", 64'(last_id), 64'(10'b010_0000100));
        step(7'b0100000, 1'b1, 1'b1);
        chk("tp second awid msb", 64'(last_awid[IDW+LN-1:IDW]), 64'(5));
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(7'h7f, 1'b1, 1'b1);
            wins[i] = last_w;
        end
        for (int i = 0; i < 8; i++) chk("all-request order", 64'(wins[i]), RR ? 64'(i % N) : 64'(0));
        step(7'b0001000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(7'b0001010, 1'b0, 1'b1);
        step(7'b0001010, 1'b1, 1'b1);
        chk("stall release winner", 64'(last_w), 64'(3));
        step(7'b0000010, 1'b1, 1'b1);
        chk("after stall winner", 64'(last_w), 64'(1));
        step(7'b0000001, 1'b1, 1'b0);
        step(7'b0000001, 1'b1, 1'b0);
        step(7'b0000001, 1'b1, 1'b1);
        chk("grant rise handshake", 64'(last_w), 64'(0));
        for (int i = 0; i < 4; i++) step(7'b1010000, 1'b1, 1'b1);
        step(7'b1000000, 1'b0, 1'b1);
        step(7'b1000000, 1'b0, 1'b1);
        do_reset();
        step(7'b1000001, 1'b1, 1'b1);
        chk("post-reset winner", 64'(last_w), 64'(0));
        for (int i = 0; i < 3000; i++)
            step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
